// File: rtl/xor_stream_packer.sv
// Packs a qualified serial bit stream LSB-first into WIDTH-bit words with even parity,
// buffers them in a DEPTH-entry FIFO, and counts words lost to a full FIFO.
module xor_stream_packer #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int DROP_W = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     en_i,
  input  logic                     bit_i,
  input  logic                     bit_valid_i,
  output logic [WIDTH-1:0]         word_o,
  output logic                     parity_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [DROP_W-1:0]        drop_cnt_o,
  output logic                     busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(WIDTH);
  localparam logic [PW-1:0] DEPTH_C = PW'(DEPTH);
  localparam logic [CW-1:0] LAST_C  = CW'(WIDTH - 1);

  typedef enum logic {IDLE, COLLECT} state_e;

  state_e            state_q;
  logic [CW-1:0]     bitCnt_q;
  logic [WIDTH-1:0]  shift_q;
  logic              parity_q;

  logic [WIDTH:0]    mem_q [DEPTH];
  logic [PW-1:0]     wrPtr_q, wrPtr_d;
  logic [PW-1:0]     rdPtr_q, rdPtr_d;
  logic [DROP_W-1:0] dropCnt_q, dropCnt_d;

  logic              lastBit;
  logic              wordDone;
  logic [WIDTH-1:0]  doneWord;
  logic              pop;
  logic              pushOk;

  assign lastBit  = (bitCnt_q == LAST_C);
  assign wordDone = (state_q == COLLECT) && en_i && bit_valid_i && lastBit;

  // Lower bits are already in place, so only the top bit comes from the wire.
  always_comb begin
    doneWord            = shift_q;
    doneWord[WIDTH-1]   = bit_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      bitCnt_q <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          bitCnt_q <= '0;
          shift_q  <= '0;
          parity_q <= 1'b0;
          if (en_i) state_q <= COLLECT;
        end
        COLLECT: begin
          if (!en_i) begin
            state_q  <= IDLE;
            bitCnt_q <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
          end else if (bit_valid_i) begin
            if (lastBit) begin
              bitCnt_q <= '0;
              shift_q  <= '0;
              parity_q <= 1'b0;
            end else begin
              shift_q[bitCnt_q] <= bit_i;
              bitCnt_q          <= bitCnt_q + 1'b1;
              parity_q          <= parity_q ^ bit_i;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign count_o = wrPtr_q - rdPtr_q;
  assign valid_o = (count_o != '0);
  assign pop     = valid_o && ready_i;
  assign busy_o  = (state_q == COLLECT);

  // A full FIFO still accepts a word when the head leaves on the same edge.
  always_comb begin
    pushOk    = wordDone && ((count_o != DEPTH_C) || pop);
    wrPtr_d   = wrPtr_q + PW'(pushOk);
    rdPtr_d   = rdPtr_q + PW'(pop);
    dropCnt_d = dropCnt_q;
    if (wordDone && !pushOk && (dropCnt_q != '1)) dropCnt_d = dropCnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      dropCnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      dropCnt_q <= dropCnt_d;
      if (pushOk) mem_q[wrPtr_q[AW-1:0]] <= {parity_q ^ bit_i, doneWord};
    end
  end

  assign {parity_o, word_o} = mem_q[rdPtr_q[AW-1:0]];
  assign drop_cnt_o         = dropCnt_q;

endmodule

// File: tb/tb_xor_stream_packer.sv
// Directed bench for xor_stream_packer; a second instance with DROP_W=2 checks saturation.
module tb_xor_stream_packer;

  logic       clk_i = 1'b0;
  logic       rst_ni, en_i, bit_i, bit_valid_i, ready_i;
  logic [7:0] word_o, satWord;
  logic       parity_o, valid_o, busy_o, satParity, satValid, satBusy;
  logic [2:0] count_o, satCount;
  logic [7:0] drop_cnt_o;
  logic [1:0] satDrop;

  int vectors = 0;
  int miscompares = 0;

  xor_stream_packer dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .bit_i(bit_i), .bit_valid_i(bit_valid_i),
    .word_o(word_o), .parity_o(parity_o), .valid_o(valid_o), .ready_i(ready_i),
    .count_o(count_o), .drop_cnt_o(drop_cnt_o), .busy_o(busy_o)
  );

  xor_stream_packer #(.WIDTH(8), .DEPTH(4), .DROP_W(2)) satDut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .bit_i(bit_i), .bit_valid_i(bit_valid_i),
    .word_o(satWord), .parity_o(satParity), .valid_o(satValid), .ready_i(ready_i),
    .count_o(satCount), .drop_cnt_o(satDrop), .busy_o(satBusy)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sendBit(input logic b);
    bit_i       = b;
    bit_valid_i = 1'b1;
    step();
    bit_valid_i = 1'b0;
    bit_i       = 1'b0;
  endtask

  // Sends one word LSB-first; optionally raises ready_i only for the final bit's edge.
  task automatic applyStimulus(input logic [7:0] w, input int gap, input logic popLast);
    for (int i = 0; i < 8; i++) begin
      if (i == 7 && popLast) ready_i = 1'b1;
      sendBit(w[i]);
      if (i < 7) for (int g = 0; g < gap; g++) step();
    end
    if (popLast) ready_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; en_i = 1'b0; bit_i = 1'b0; bit_valid_i = 1'b0; ready_i = 1'b0;
    #2;
    checkOutput("rst_word",   32'(word_o),     32'h0);
    checkOutput("rst_parity", 32'(parity_o),   32'h0);
    checkOutput("rst_valid",  32'(valid_o),    32'h0);
    checkOutput("rst_count",  32'(count_o),    32'h0);
    checkOutput("rst_drop",   32'(drop_cnt_o), 32'h0);
    checkOutput("rst_busy",   32'(busy_o),     32'h0);
    #10 rst_ni = 1'b1;
    step();

    $display("[TB] basic word");
    en_i = 1'b1; ready_i = 1'b1;
    step();
    checkOutput("busy_rise", 32'(busy_o), 32'h1);
    applyStimulus(8'hA5, 0, 1'b0);
    checkOutput("basic_valid",  32'(valid_o),  32'h1);
    checkOutput("basic_word",   32'(word_o),   32'hA5);
    checkOutput("basic_parity", 32'(parity_o), 32'h0);
    step();
    checkOutput("basic_popped", 32'(valid_o), 32'h0);
    checkOutput("basic_count",  32'(count_o), 32'h0);

    $display("[TB] gapped valids");
    applyStimulus(8'h07, 2, 1'b0);
    checkOutput("gap_valid",  32'(valid_o),  32'h1);
    checkOutput("gap_word",   32'(word_o),   32'h07);
    checkOutput("gap_parity", 32'(parity_o), 32'h1);
    step();
    checkOutput("gap_single", 32'(valid_o), 32'h0);

    $display("[TB] back-pressure and drop");
    ready_i = 1'b0;
    for (int k = 1; k <= 5; k++) applyStimulus(8'(k), 0, 1'b0);
    checkOutput("bp_count", 32'(count_o),    32'h4);
    checkOutput("bp_drop",  32'(drop_cnt_o), 32'h1);
    checkOutput("bp_stall", 32'(word_o),     32'h01);
    step();
    checkOutput("bp_stable", 32'(word_o), 32'h01);
    ready_i = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checkOutput("bp_pop_valid", 32'(valid_o), 32'h1);
      checkOutput("bp_pop_word",  32'(word_o),  32'(k));
      step();
    end
    checkOutput("bp_empty", 32'(valid_o), 32'h0);

    $display("[TB] full with simultaneous pop");
    ready_i = 1'b0;
    for (int k = 1; k <= 4; k++) applyStimulus(8'(k), 0, 1'b0);
    applyStimulus(8'h06, 0, 1'b1);
    checkOutput("full_count", 32'(count_o),    32'h4);
    checkOutput("full_drop",  32'(drop_cnt_o), 32'h1);
    ready_i = 1'b1;
    checkOutput("full_pop0", 32'(word_o), 32'h02); step();
    checkOutput("full_pop1", 32'(word_o), 32'h03); step();
    checkOutput("full_pop2", 32'(word_o), 32'h04); step();
    checkOutput("full_pop3", 32'(word_o), 32'h06); step();
    checkOutput("full_empty", 32'(valid_o), 32'h0);

    $display("[TB] enable abort");
    sendBit(1'b1); sendBit(1'b1); sendBit(1'b1);
    en_i = 1'b0;
    step();
    checkOutput("abort_busy0", 32'(busy_o), 32'h0);
    step();
    checkOutput("abort_busy1", 32'(busy_o),  32'h0);
    checkOutput("abort_valid", 32'(valid_o), 32'h0);
    en_i = 1'b1; bit_valid_i = 1'b1; bit_i = 1'b0;
    step();
    bit_valid_i = 1'b0;
    checkOutput("abort_busy_back", 32'(busy_o), 32'h1);
    applyStimulus(8'hFF, 0, 1'b0);
    checkOutput("abort_valid_ff", 32'(valid_o),  32'h1);
    checkOutput("abort_word",     32'(word_o),   32'hFF);
    checkOutput("abort_parity",   32'(parity_o), 32'h0);
    checkOutput("abort_count",    32'(count_o),  32'h1);
    step();
    checkOutput("abort_only_one", 32'(valid_o), 32'h0);

    $display("[TB] async reset");
    ready_i = 1'b0;
    applyStimulus(8'h11, 0, 1'b0);
    applyStimulus(8'h22, 0, 1'b0);
    sendBit(1'b1); sendBit(1'b0); sendBit(1'b1);
    checkOutput("ar_pre_count", 32'(count_o), 32'h2);
    #2 rst_ni = 1'b0;
    #1;
    checkOutput("ar_word",   32'(word_o),     32'h0);
    checkOutput("ar_parity", 32'(parity_o),   32'h0);
    checkOutput("ar_valid",  32'(valid_o),    32'h0);
    checkOutput("ar_count",  32'(count_o),    32'h0);
    checkOutput("ar_drop",   32'(drop_cnt_o), 32'h0);
    checkOutput("ar_busy",   32'(busy_o),     32'h0);
    #2 rst_ni = 1'b1;
    step();
    step();
    checkOutput("ar_no_stale_valid", 32'(valid_o), 32'h0);
    checkOutput("ar_no_stale_count", 32'(count_o), 32'h0);
    checkOutput("ar_no_stale_word",  32'(word_o),  32'h0);

    $display("[TB] drop saturation");
    for (int k = 1; k <= 12; k++) applyStimulus(8'(k), 0, 1'b0);
    checkOutput("sat_main_drop",  32'(drop_cnt_o), 32'h8);
    checkOutput("sat_main_count", 32'(count_o),    32'h4);
    checkOutput("sat_drop",       32'(satDrop),    32'h3);
    checkOutput("sat_count",      32'(satCount),   32'h4);
    checkOutput("sat_head",       32'(satWord),    32'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
